uart_rx: RTL and testbench

Serial receiver for the UART link on the MIPS system. It sits directly upstream of the processor's memory-mapped UART data register, which drains it. It samples the asynchronous `UART_rx` pin, deframes 8N1 characters (LSB first), and presents each byte on a single-entry ready/valid holding register. Framing errors and overruns are reported as single-cycle pulses.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_sync_2ff.sv | 25 ++
 rtl/uart_rx.sv | 152 +++++++++++++++
 tb/tb_uart_rx.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and link-wide constants.
package uart_pkg;

    localparam int UART_DEFAULT_CLKS_PER_BIT = 868;  // 100 MHz / 115200
    localparam int UART_DATA_BITS            = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a
// parameterized reset value so idle-high lines come out of reset idle.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes the pin, deframes LSB-first characters
// and presents each byte in a single-entry valid/ready holding register.
//
// Handshake: rx_valid stays high while rx_data holds an undelivered byte; a
// transfer happens on any rising edge where rx_valid & rx_ready are both 1.
// rx_ready only influences registered state, never an output directly.
// DATA_BITS must be at least 2; CLKS_PER_BIT must be even and at least 8.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 UART_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy,
    output uart_rx_state_t       dbg_state
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);

    uart_rx_state_t state, state_next;

    logic                 rx_s;
    logic                 rx_prev;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;

    logic cnt_clr;
    logic shift_en;
    logic byte_done;
    logic stop_bad;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (UART_rx),
        .q     (rx_s)
    );

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state decode and per-cycle datapath strobes.
    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        shift_en   = 1'b0;
        byte_done  = 1'b0;
        stop_bad   = 1'b0;
        case (state)
            IDLE: begin
                // A high-to-low transition of the synced line starts a frame.
                if (rx_prev && !rx_s) begin
                    state_next = START;
                    cnt_clr    = 1'b1;
                end
            end
            START: begin
                // Mid start bit: still low means a real start, else a glitch.
                if (cnt == HALF_LAST) begin
                    cnt_clr    = 1'b1;
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    shift_en = 1'b1;
                    if (bit_idx == IDX_LAST) state_next = STOP;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    if (rx_s) begin
                        byte_done  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        stop_bad   = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                // Line stuck low: wait for it to return high before rearming.
                if (rx_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Edge-detect history, bit-time counter, bit index and shift register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_prev <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            rx_prev <= rx_s;
            if (cnt_clr || cnt == BIT_LAST) cnt <= '0;
            else                            cnt <= cnt + CW'(1);
            if (cnt_clr)       bit_idx <= '0;
            else if (shift_en) bit_idx <= bit_idx + BW'(1);
            if (shift_en) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
        end
    end

    // Holding register and registered error pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= 1'b0;
            if (byte_done) begin
                // Load when empty or being drained this same cycle.
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clocks per bit: directed corner sequences, a
// vector table of frames, and randomized frames against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB = 16;
    localparam int DB  = 8;

    logic           clk;
    logic           rst_n;
    logic           UART_rx;
    logic [DB-1:0]  rx_data;
    logic           rx_valid;
    logic           rx_ready;
    logic           frame_err;
    logic           overrun;
    logic           busy;
    uart_rx_state_t dbg_state;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    int         ferr_cnt = 0;
    int         ovr_cnt  = 0;
    bit         rand_ready = 0;
    int         lat_valid;
    int         lat_busy;

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        bit         drain;
        bit         exp_valid;
        logic [7:0] exp_data;
        int         exp_ferr;
        int         exp_ovr;
    } vec_t;

    vec_t vecs[7];

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .UART_rx   (UART_rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Scoreboard: pulse widths are counted in cycles; every transfer is
    // compared against the front of the expected queue.
    always @(negedge clk) begin
        if (frame_err === 1'b1) ferr_cnt++;
        if (overrun === 1'b1) ovr_cnt++;
        if (rst_n === 1'b1 && rx_valid === 1'b1 && rx_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL xfer_unexpected: got %02h want none", rx_data);
            end else begin
                check("xfer_data", 32'(rx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
            tick();
        end
    endtask

    task automatic drain();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    // Line level c cycles into a frame: start, LSB-first data, stop.
    function automatic logic line_bit(input logic [7:0] data, input bit stop_ok, input int c);
        int b;
        b = c / CPB;
        if (b == 0)       return 1'b0;
        else if (b <= DB) return data[b-1];
        else              return stop_ok;
    endfunction

    // Drives one frame; a bad stop bit holds the line low for 40 cycles.
    // ready_cyc > 0 pulses rx_ready so it is sampled on that rising edge.
    task automatic send_frame(input logic [7:0] data, input bit stop_ok, input int ready_cyc);
        int len;
        bit v0;
        len       = stop_ok ? 10 * CPB : 9 * CPB + 40;
        v0        = rx_valid;
        lat_valid = -1;
        lat_busy  = -1;
        for (int c = 0; c < len; c++) begin
            UART_rx = line_bit(data, stop_ok, c);
            if (ready_cyc > 0)   rx_ready = (c + 1 == ready_cyc);
            else if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
            tick();
            if (lat_busy < 0 && busy) lat_busy = c + 1;
            if (lat_valid < 0 && rx_valid && !v0) lat_valid = c + 1;
        end
        UART_rx = 1'b1;
    endtask

    initial begin
        int  f0;
        int  o0;
        int  exp_ferr;
        bit  seen;
        logic [7:0] d;
        bit  ok;

        // Reset.
        rst_n    = 1'b0;
        UART_rx  = 1'b1;
        rx_ready = 1'b0;
        repeat (2) tick();
        check("rst_data", 32'(rx_data), 32'h0);
        check("rst_valid", 32'(rx_valid), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        check("rst_ovr", 32'(overrun), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;
        idle(5);

        // Basic receive with latency and busy timing.
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1, 0);
        check("basic_busy_lat", 32'(lat_busy), 32'd3);
        check("basic_valid_lat", 32'(lat_valid), 32'd155);
        idle(20);
        check("basic_valid", 32'(rx_valid), 32'h1);
        check("basic_data", 32'(rx_data), 32'hA5);
        check("basic_busy_idle", 32'(busy), 32'h0);
        drain();
        tick();
        check("basic_drained", 32'(rx_valid), 32'h0);
        check("basic_data_kept", 32'(rx_data), 32'hA5);

        // Glitch rejection.
        f0   = ferr_cnt;
        seen = 0;
        UART_rx = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (busy) seen = 1;
        end
        UART_rx = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (busy) seen = 1;
        end
        check("glitch_busy_seen", 32'(seen), 32'h1);
        check("glitch_busy_end", 32'(busy), 32'h0);
        check("glitch_valid", 32'(rx_valid), 32'h0);
        check("glitch_ferr", 32'(ferr_cnt - f0), 32'h0);

        // Vector table: each row is sent with rx_ready low.
        vecs[0] = '{8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 0, 0};
        vecs[1] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'h00, 0, 1};
        vecs[2] = '{8'h81, 1'b1, 1'b1, 1'b1, 8'h81, 0, 0};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'h81, 1, 0};
        vecs[4] = '{8'h5A, 1'b1, 1'b0, 1'b1, 8'h5A, 0, 0};
        vecs[5] = '{8'h80, 1'b0, 1'b1, 1'b1, 8'h5A, 1, 0};
        vecs[6] = '{8'h01, 1'b1, 1'b1, 1'b1, 8'h01, 0, 0};
        for (int i = 0; i < 7; i++) begin
            f0 = ferr_cnt;
            o0 = ovr_cnt;
            if (vecs[i].stop_ok && vecs[i].exp_ovr == 0) exp_q.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop_ok, 0);
            idle(20);
            check($sformatf("vec%0d_valid", i), 32'(rx_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_data", i), 32'(rx_data), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_ferr", i), 32'(ferr_cnt - f0), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d_ovr", i), 32'(ovr_cnt - o0), 32'(vecs[i].exp_ovr));
            if (vecs[i].drain) begin
                drain();
                tick();
                check($sformatf("vec%0d_drained", i), 32'(rx_valid), 32'h0);
            end
        end

        // Overrun, then accept exactly in the completion cycle.
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1, 0);
        idle(10);
        o0 = ovr_cnt;
        send_frame(8'h22, 1, 0);
        idle(10);
        check("ovr_pulse", 32'(ovr_cnt - o0), 32'h1);
        check("ovr_data", 32'(rx_data), 32'h11);
        check("ovr_valid", 32'(rx_valid), 32'h1);
        drain();
        idle(5);
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1, 0);
        idle(10);
        exp_q.push_back(8'h22);
        o0 = ovr_cnt;
        send_frame(8'h22, 1, 155);
        idle(10);
        check("same_cycle_ovr", 32'(ovr_cnt - o0), 32'h0);
        check("same_cycle_data", 32'(rx_data), 32'h22);
        check("same_cycle_valid", 32'(rx_valid), 32'h1);
        drain();
        idle(5);

        // Reset during bit 3 of 0x0F.
        f0 = ferr_cnt;
        for (int c = 0; c < 70; c++) begin
            UART_rx = line_bit(8'h0F, 1, c);
            tick();
        end
        rst_n   = 1'b0;
        UART_rx = 1'b1;
        tick();
        rst_n = 1'b1;
        check("midrst_busy_now", 32'(busy), 32'h0);
        idle(32);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_valid", 32'(rx_valid), 32'h0);
        check("midrst_data", 32'(rx_data), 32'h0);
        check("midrst_state", 32'(dbg_state), 32'(IDLE));
        check("midrst_ferr", 32'(ferr_cnt - f0), 32'h0);
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 1, 0);
        idle(10);
        check("after_rst_valid", 32'(rx_valid), 32'h1);
        check("after_rst_data", 32'(rx_data), 32'hFF);
        drain();
        idle(5);

        // Random frames with a randomly toggling consumer.
        rand_ready = 1;
        f0       = ferr_cnt;
        o0       = ovr_cnt;
        exp_ferr = 0;
        for (int n = 0; n < 12; n++) begin
            d  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 5) != 0);
            if (ok) exp_q.push_back(d);
            else    exp_ferr++;
            send_frame(d, ok, 0);
            if (!ok) idle(CPB);
            idle($urandom_range(0, 20));
        end
        rand_ready = 0;
        rx_ready   = 1'b1;
        repeat (10) tick();
        rx_ready = 1'b0;
        tick();
        check("rand_ferr", 32'(ferr_cnt - f0), 32'(exp_ferr));
        check("rand_ovr", 32'(ovr_cnt - o0), 32'h0);
        check("rand_valid_end", 32'(rx_valid), 32'h0);
        check("exp_q_empty", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
